csa_accum_ctrl: RTL

Streaming multi-operand accumulator controller built around a carry-save adder row. Accepts a frame of W-bit operands one per cycle over a valid/ready handshake and keeps the running total in redundant sum/carry form, so no carry ripples during accumulation. When the frame's last operand arrives, it performs a single resolving add and presents the total with an operand count and an overflow flag. Sits between an operand source (e.g. a sample stream) and a result consumer.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_accum_ctrl_if.sv | 26 ++
 rtl/csa_row.sv | 20 ++
 rtl/fa.sv | 11 +
 rtl/csa_accum_ctrl.sv | 111 +++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save accumulator controller.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  function automatic int unsigned acc_width(input int unsigned w, input int unsigned max_ops);
    return w + $clog2(max_ops);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_ops);
    return $clog2(max_ops) + 1;
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Operand stream in, result out: the block sits on the slave side.
interface csa_accum_ctrl_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 5
) ();
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_row.sv
// N-bit 3:2 compressor: one full adder per bit, no carry propagation.
module csa_row #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (carry[i])
    );
  end
endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/csa_accum_ctrl.sv
// Frame accumulator: running total kept as sum/carry, resolved once per frame.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned MAX_OPS = 16
) (
  input logic            clk,
  input logic            rst_n,
  csa_accum_ctrl_if.slave bus
);
  localparam int unsigned ACC_W = acc_width(W, MAX_OPS);
  localparam int unsigned CNT_W = cnt_width(MAX_OPS);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q, cs, x, row_s, row_c;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] res_sum_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic             res_ovf_q;
  logic             in_ready, beat, load, step, resolve, clear;

  assign x  = {{(ACC_W-W){1'b0}}, bus.in_data};
  assign cs = {c_q[ACC_W-2:0], 1'b0};

  csa_row #(.N(ACC_W)) u_row (
    .a     (s_q),
    .b     (cs),
    .c     (x),
    .sum   (row_s),
    .carry (row_c)
  );

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign beat     = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    resolve = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (beat) begin
        load    = 1'b1;
        state_d = bus.in_last ? RESOLVE : ACCUM;
      end
      ACCUM: if (beat) begin
        step = 1'b1;
        if (bus.in_last) state_d = RESOLVE;
      end
      RESOLVE: begin
        resolve = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: if (bus.out_ready) begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      if (load) begin
        s_q   <= x;
        c_q   <= '0;
        cnt_q <= CNT_W'(1);
        ovf_q <= 1'b0;
      end
      if (step) begin
        s_q <= row_s;
        c_q <= row_c;
        if (cnt_q != '1)                cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAX_OPS))   ovf_q <= 1'b1;
      end
      if (resolve) begin
        res_sum_q <= s_q + cs;
        res_cnt_q <= cnt_q;
        res_ovf_q <= ovf_q;
      end
      if (clear) begin
        s_q   <= '0;
        c_q   <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_sum   = res_sum_q;
  assign bus.out_count = res_cnt_q;
  assign bus.out_ovf   = res_ovf_q;
endmodule
